// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, frame layout and frame builder for the UART transmitter.
// Macro UART_TX_PARITY_EN selects the 11-bit frame with even parity; undefined gives a 10-bit frame.
package uart_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int UART_DATA_W    = 8;
    localparam int UART_FRAME_W   = 11;
    localparam int FRAME_START    = 0;
    localparam int FRAME_DATA_LSB = 1;
    localparam int FRAME_PARITY   = 9;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_STOP     = 10;
    localparam int FRAME_BITS     = 11;
`else
    localparam int FRAME_STOP     = 9;
    localparam int FRAME_BITS     = 10;
`endif

    function automatic logic [UART_FRAME_W-1:0] build_frame(input logic [UART_DATA_W-1:0] d);
        logic [UART_FRAME_W-1:0] f;
        f = '1;
        f[FRAME_START] = 1'b0;
        f[FRAME_DATA_LSB +: UART_DATA_W] = d;
`ifdef UART_TX_PARITY_EN
        f[FRAME_PARITY] = ^d;
`else
        f[FRAME_PARITY] = 1'b1;
`endif
        f[FRAME_STOP] = 1'b1;
        return f;
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, pulses bit_done on the last clock of each serial bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic rxclk,
    input  logic rxreset,
    input  logic clr,
    input  logic en,
    output logic bit_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign bit_done = en && (cnt == CW'(CLKS_PER_BIT - 1));

    // count clocks within a bit, wrapping at the end of each bit period
    always_ff @(posedge rxclk or posedge rxreset) begin
        if (rxreset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= bit_done ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmit line among NREQ byte producers.
// Define UART_TX_PARITY_EN for 11-bit frames with even parity; default build sends 10-bit frames.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                        rxclk,
    input  logic                        rxreset,
    input  logic [NREQ-1:0]             req,
    input  logic [UART_DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]             grant,
    output logic                        busy,
    output logic [$clog2(NREQ)-1:0]     cur_id,
    output logic [UART_FRAME_W-1:0]     frame,
    output logic                        txd
);
    localparam int IDW = $clog2(NREQ);

    state_t                 state;
    logic [IDW-1:0]         last;
    logic [IDW-1:0]         win;
    logic [NREQ-1:0]        win_oh;
    logic [UART_DATA_W-1:0] win_data;
    logic [3:0]             bit_idx;
    logic [3:0]             nxt_idx;
    logic                   bit_done;

    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] l);
        rr_pick = l;
        for (int k = NREQ; k >= 1; k--)
            if (r[(int'(l) + k) % NREQ])
                rr_pick = IDW'((int'(l) + k) % NREQ);
    endfunction

    assign win      = rr_pick(req, last);
    assign win_oh   = NREQ'(1) << win;
    assign win_data = req_data[UART_DATA_W*win +: UART_DATA_W];
    assign nxt_idx  = bit_idx + 4'd1;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .rxclk    (rxclk),
        .rxreset  (rxreset),
        .clr      (state == IDLE),
        .en       (state == SHIFT),
        .bit_done (bit_done)
    );

    // arbitrate in IDLE, then shift the captured frame out one bit per baud period
    always_ff @(posedge rxclk or posedge rxreset) begin
        if (rxreset) begin
            state   <= IDLE;
            last    <= IDW'(NREQ - 1);
            grant   <= '0;
            busy    <= 1'b0;
            cur_id  <= '0;
            frame   <= '0;
            txd     <= 1'b1;
            bit_idx <= '0;
        end else begin
            grant <= '0;
            if (state == IDLE) begin
                if (|req) begin
                    grant   <= win_oh;
                    cur_id  <= win;
                    last    <= win;
                    frame   <= build_frame(win_data);
                    bit_idx <= '0;
                    busy    <= 1'b1;
                    txd     <= 1'b0;
                    state   <= SHIFT;
                end
            end else if (bit_done) begin
                if (bit_idx == 4'(FRAME_BITS - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    txd   <= 1'b1;
                end else begin
                    bit_idx <= nxt_idx;
                    txd     <= frame[nxt_idx];
                end
            end
        end
    end
endmodule
